// File: rtl/sdr_rd_stream_if.sv
// Request, SDRAM pin and read-stream bundle for the streaming read engine.
// master = engine side, slave = SDRAM top / consumer side.
interface sdr_rd_stream_if;
  logic        sdr_rd_req;
  logic [11:0] sdr_rd_byte_cnt;
  logic [1:0]  sdr_bank_addr;
  logic [12:0] sdr_row_addr;
  logic [8:0]  sdr_col_addr;
  logic        sdr_CKE;
  logic        sdr_nCS;
  logic        sdr_nRAS;
  logic        sdr_nCAS;
  logic        sdr_nWE;
  logic [1:0]  sdr_BA;
  logic [12:0] sdr_A;
  logic [1:0]  sdr_DQM;
  logic [15:0] sdr_DQ_in;
  logic [15:0] sdr_rdata_out;
  logic        sdr_rd_vld;
  logic        sdr_rdata_ready;
  logic        rd_busy;
  logic        rd_exit;

  modport master (
    input  sdr_rd_req,
    input  sdr_rd_byte_cnt,
    input  sdr_bank_addr,
    input  sdr_row_addr,
    input  sdr_col_addr,
    output sdr_CKE,
    output sdr_nCS,
    output sdr_nRAS,
    output sdr_nCAS,
    output sdr_nWE,
    output sdr_BA,
    output sdr_A,
    output sdr_DQM,
    input  sdr_DQ_in,
    output sdr_rdata_out,
    output sdr_rd_vld,
    input  sdr_rdata_ready,
    output rd_busy,
    output rd_exit
  );

  modport slave (
    output sdr_rd_req,
    output sdr_rd_byte_cnt,
    output sdr_bank_addr,
    output sdr_row_addr,
    output sdr_col_addr,
    input  sdr_CKE,
    input  sdr_nCS,
    input  sdr_nRAS,
    input  sdr_nCAS,
    input  sdr_nWE,
    input  sdr_BA,
    input  sdr_A,
    input  sdr_DQM,
    output sdr_DQ_in,
    input  sdr_rdata_out,
    input  sdr_rd_vld,
    output sdr_rdata_ready,
    input  rd_busy,
    input  rd_exit
  );
endinterface

// File: rtl/sdr_rd_stream.sv
// Streaming SDRAM read engine: one row open, single-word READs per column,
// CAS-latency capture into a FWFT read FIFO, then precharge.
module sdr_rd_stream #(
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 3,
  parameter int T_RP    = 3,
  parameter int FIFO_AW = 4
) (
  input  logic clk,
  input  logic rst_n,
  sdr_rd_stream_if.master bus
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 2;

  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_PRE = 4'b0010;

  localparam logic [7:0] RCD_LD = 8'(T_RCD > 1 ? T_RCD - 2 : 0);
  localparam logic [7:0] RP_LD  = 8'(T_RP > 1 ? T_RP - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, ACT, RCD, READ, DRAIN, PRE, RP, DONE
  } state_t;

  state_t state;

  logic [1:0]  ba_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [11:0] left_q;
  logic [7:0]  tmr_q;

  logic [3:0]  cmd_q;
  logic [1:0]  ba_o;
  logic [12:0] a_o;
  logic [1:0]  dqm_o;
  logic        busy_q;
  logic        exit_q;

  logic [CAS_LAT:0] pipe_q;

  logic [FIFO_AW:0]   cnt_q;
  logic [FIFO_AW-1:0] wp_q;
  logic [FIFO_AW-1:0] rp_q;
  logic [15:0]        mem [DEPTH];

  logic [CW-1:0] in_flight;
  logic [12:0]   words;
  logic          credit;
  logic          issue;
  logic          push;
  logic          pop;
  logic          vld;

  assign words = (13'(bus.sdr_rd_byte_cnt) + 13'd1) >> 1;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= CAS_LAT; i++)
      in_flight = in_flight + CW'(pipe_q[i]);
  end

  // Reserve a FIFO slot for every READ still in the CAS pipe.
  assign credit = (CW'(cnt_q) + in_flight) < CW'(DEPTH);
  assign issue  = (state == READ) && credit;
  assign push   = pipe_q[CAS_LAT];
  assign vld    = (cnt_q != '0);
  assign pop    = vld && bus.sdr_rdata_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ba_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      left_q <= '0;
      tmr_q  <= '0;
      cmd_q  <= C_DES;
      ba_o   <= '0;
      a_o    <= '0;
      dqm_o  <= 2'b11;
      busy_q <= 1'b0;
      exit_q <= 1'b0;
    end else begin
      exit_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_q <= C_DES;
          if (bus.sdr_rd_req) begin
            ba_q   <= bus.sdr_bank_addr;
            row_q  <= bus.sdr_row_addr;
            col_q  <= bus.sdr_col_addr;
            left_q <= words[11:0];
            busy_q <= 1'b1;
            cmd_q  <= C_NOP;
            state  <= (words == '0) ? DONE : ACT;
          end
        end
        ACT: begin
          cmd_q <= C_ACT;
          a_o   <= row_q;
          ba_o  <= ba_q;
          dqm_o <= 2'b00;
          if (T_RCD == 1) begin
            state <= READ;
          end else begin
            tmr_q <= RCD_LD;
            state <= RCD;
          end
        end
        RCD: begin
          cmd_q <= C_NOP;
          if (tmr_q == '0) state <= READ;
          else             tmr_q <= tmr_q - 8'd1;
        end
        READ: begin
          if (issue) begin
            cmd_q  <= C_RD;
            a_o    <= {4'b0, col_q};
            col_q  <= col_q + 9'd1;
            left_q <= left_q - 12'd1;
            if (left_q == 12'd1) state <= DRAIN;
          end else begin
            cmd_q <= C_NOP;
          end
        end
        DRAIN: begin
          cmd_q <= C_NOP;
          if (in_flight == '0) state <= PRE;
        end
        PRE: begin
          cmd_q <= C_PRE;
          a_o   <= '0;
          ba_o  <= ba_q;
          dqm_o <= 2'b11;
          if (T_RP == 1) begin
            state <= DONE;
          end else begin
            tmr_q <= RP_LD;
            state <= RP;
          end
        end
        RP: begin
          cmd_q <= C_NOP;
          if (tmr_q == '0) state <= DONE;
          else             tmr_q <= tmr_q - 8'd1;
        end
        DONE: begin
          cmd_q  <= C_DES;
          exit_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= {pipe_q[CAS_LAT-1:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (FIFO_AW+1)'(push)
                     - (FIFO_AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= bus.sdr_DQ_in;
  end

  assign bus.sdr_CKE       = 1'b1;
  assign bus.sdr_nCS       = cmd_q[3];
  assign bus.sdr_nRAS      = cmd_q[2];
  assign bus.sdr_nCAS      = cmd_q[1];
  assign bus.sdr_nWE       = cmd_q[0];
  assign bus.sdr_BA        = ba_o;
  assign bus.sdr_A         = a_o;
  assign bus.sdr_DQM       = dqm_o;
  assign bus.sdr_rd_vld    = vld;
  assign bus.sdr_rdata_out = vld ? mem[rp_q] : 16'h0000;
  assign bus.rd_busy       = busy_q;
  assign bus.rd_exit       = exit_q;

endmodule

// File: tb/tb_sdr_rd_stream.sv
// Directed bench for sdr_rd_stream with a CAS-latency SDRAM read model
// and a pin-level command/data monitor.
module tb_sdr_rd_stream;

  localparam int CL   = 3;
  localparam int TRCD = 3;
  localparam int TRP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdr_rd_stream_if bus();

  sdr_rd_stream #(
    .CAS_LAT(CL),
    .T_RCD(TRCD),
    .T_RP(TRP),
    .FIFO_AW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #3 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [1:0] b,
                                           input logic [12:0] r,
                                           input logic [8:0] c);
    return {b, r[4:0], c};
  endfunction

  int cyc = 0;
  int act_n, rd_n, pre_n, exit_n;
  int act_cyc, rd1_cyc, pre_cyc, exit_cyc, req_cyc;
  int max_out;
  logic [12:0] act_a;
  logic [1:0]  act_ba;
  logic [1:0]  pre_ba;
  logic        dqm_bad;
  logic [8:0]  rd_col[$];
  logic [15:0] pop_q[$];
  logic        hv[8];
  logic [15:0] hd[8];

  task automatic clr();
    act_n = 0; rd_n = 0; pre_n = 0; exit_n = 0;
    act_cyc = 0; rd1_cyc = 0; pre_cyc = 0;
    exit_cyc = 0; req_cyc = -1; max_out = 0;
    act_a = '0; act_ba = '0; pre_ba = '0;
    dqm_bad = 1'b0;
    rd_col.delete();
    pop_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hv[i] = 1'b0;
      hd[i] = 16'hDEAD;
    end
    clr();
  end

  // SDRAM read model + pin monitor, all sampled on the falling edge
  always @(negedge clk) begin
    logic [3:0] cmd;
    cyc++;
    cmd = {bus.sdr_nCS, bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE};
    for (int i = 7; i > 0; i--) begin
      hv[i] = hv[i-1];
      hd[i] = hd[i-1];
    end
    hv[0] = 1'b0;
    hd[0] = 16'hDEAD;
    if (rst_n) begin
      if (cmd == 4'b0011) begin
        act_n++;
        act_cyc = cyc;
        act_a = bus.sdr_A;
        act_ba = bus.sdr_BA;
      end
      if (cmd == 4'b0101) begin
        if (rd_n == 0) rd1_cyc = cyc;
        rd_n++;
        rd_col.push_back(bus.sdr_A[8:0]);
        if (bus.sdr_DQM != 2'b00) dqm_bad = 1'b1;
        hv[0] = 1'b1;
        hd[0] = mem_word(act_ba, act_a, bus.sdr_A[8:0]);
      end
      if (cmd == 4'b0010) begin
        pre_n++;
        pre_cyc = cyc;
        pre_ba = bus.sdr_BA;
      end
      if (bus.rd_exit) begin
        exit_n++;
        exit_cyc = cyc;
      end
      if (bus.sdr_rd_req && !bus.rd_busy && req_cyc < 0)
        req_cyc = cyc;
      if (bus.sdr_rd_vld && bus.sdr_rdata_ready)
        pop_q.push_back(bus.sdr_rdata_out);
      if (rd_n - pop_q.size() > max_out)
        max_out = rd_n - pop_q.size();
    end
    bus.sdr_DQ_in = hv[CL] ? hd[CL] : 16'hDEAD;
  end

  task automatic start(input logic [1:0] b, input logic [12:0] r,
                       input logic [8:0] c, input logic [11:0] n);
    @(posedge clk);
    #1;
    clr();
    bus.sdr_bank_addr   = b;
    bus.sdr_row_addr    = r;
    bus.sdr_col_addr    = c;
    bus.sdr_rd_byte_cnt = n;
    bus.sdr_rd_req      = 1'b1;
    @(posedge clk);
    #1;
    bus.sdr_rd_req = 1'b0;
  endtask

  task automatic wait_exit(input int budget);
    int n = 0;
    while (exit_n == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic chk_stream(input string tag, input int words,
                            input logic [1:0] b, input logic [12:0] r,
                            input logic [8:0] c);
    logic [8:0] col;
    chk({tag, "_rd_n"}, rd_n, words);
    chk({tag, "_pops"}, pop_q.size(), words);
    for (int i = 0; i < words; i++) begin
      col = c + 9'(i);
      chk({tag, "_col"},
          (i < rd_col.size()) ? 32'(rd_col[i]) : 32'hFFFF_FFFF,
          32'(col));
      chk({tag, "_data"},
          (i < pop_q.size()) ? 32'(pop_q[i]) : 32'hFFFF_FFFF,
          32'(mem_word(b, r, col)));
    end
  endtask

  initial begin
    bus.sdr_rd_req      = 1'b0;
    bus.sdr_rd_byte_cnt = '0;
    bus.sdr_bank_addr   = '0;
    bus.sdr_row_addr    = '0;
    bus.sdr_col_addr    = '0;
    bus.sdr_rdata_ready = 1'b0;
    bus.sdr_DQ_in       = 16'hDEAD;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {bus.sdr_nCS, bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE}, 4'hF);
    chk("rst_cke", bus.sdr_CKE, 1);
    chk("rst_dqm", bus.sdr_DQM, 2'b11);
    chk("rst_a_ba", {bus.sdr_BA, bus.sdr_A}, 0);
    chk("rst_vld", bus.sdr_rd_vld, 0);
    chk("rst_rdata", bus.sdr_rdata_out, 0);
    chk("rst_busy_exit", {bus.rd_busy, bus.rd_exit}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic 4-word read
    bus.sdr_rdata_ready = 1'b1;
    start(2'd1, 13'h0123, 9'h010, 12'd8);
    wait_exit(100);
    repeat (30) @(posedge clk);
    chk("t1_act_n", act_n, 1);
    chk("t1_act_a", act_a, 13'h0123);
    chk("t1_act_ba", act_ba, 1);
    chk("t1_rcd", rd1_cyc - act_cyc, TRCD);
    chk("t1_dqm", dqm_bad, 0);
    chk("t1_pre_n", pre_n, 1);
    chk("t1_pre_ba", pre_ba, 1);
    chk("t1_pre_after_rd", pre_cyc > rd1_cyc + 3, 1);
    chk("t1_rp", exit_cyc - pre_cyc, TRP);
    chk("t1_exit_n", exit_n, 1);
    chk_stream("t1", 4, 2'd1, 13'h0123, 9'h010);

    // odd byte count rounds up
    start(2'd2, 13'h00A5, 9'h100, 12'd3);
    wait_exit(100);
    repeat (30) @(posedge clk);
    chk("t2_exit_n", exit_n, 1);
    chk("t2_pre_n", pre_n, 1);
    chk_stream("t2", 2, 2'd2, 13'h00A5, 9'h100);

    // zero-length request
    start(2'd0, 13'h0005, 9'h007, 12'd0);
    wait_exit(20);
    repeat (5) @(posedge clk);
    chk("t3_cmds", act_n + rd_n + pre_n, 0);
    chk("t3_exit_n", exit_n, 1);
    chk("t3_exit_lat", exit_cyc - req_cyc, 2);
    chk("t3_pops", pop_q.size(), 0);

    // back-pressure: FIFO fills to 16, then resumes
    bus.sdr_rdata_ready = 1'b0;
    start(2'd3, 13'h1FFF, 9'h020, 12'd64);
    repeat (60) @(posedge clk);
    #1;
    chk("t4_stall_rd", rd_n, 16);
    chk("t4_stall_vld", bus.sdr_rd_vld, 1);
    chk("t4_stall_busy", bus.rd_busy, 1);
    chk("t4_stall_pops", pop_q.size(), 0);
    bus.sdr_rdata_ready = 1'b1;
    wait_exit(300);
    repeat (40) @(posedge clk);
    chk("t4_max_out", max_out, 16);
    chk("t4_exit_n", exit_n, 1);
    chk_stream("t4", 32, 2'd3, 13'h1FFF, 9'h020);

    // column wrap inside the row
    start(2'd0, 13'h0042, 9'h1FE, 12'd8);
    wait_exit(100);
    repeat (30) @(posedge clk);
    chk("t5_act_a", act_a, 13'h0042);
    chk_stream("t5", 4, 2'd0, 13'h0042, 9'h1FE);

    // reset while draining
    bus.sdr_rdata_ready = 1'b0;
    start(2'd1, 13'h0777, 9'h000, 12'd8);
    begin
      int n = 0;
      while (rd_n < 4 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    chk("t6_rd4", rd_n, 4);
    @(posedge clk);
    @(negedge clk);
    chk("t6_vld_pre", bus.sdr_rd_vld, 1);
    chk("t6_pre_n", pre_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd", {bus.sdr_nCS, bus.sdr_nRAS, bus.sdr_nCAS, bus.sdr_nWE}, 4'hF);
    chk("t6_rst_dqm", bus.sdr_DQM, 2'b11);
    chk("t6_rst_a", bus.sdr_A, 0);
    chk("t6_rst_vld", bus.sdr_rd_vld, 0);
    chk("t6_rst_rdata", bus.sdr_rdata_out, 0);
    chk("t6_rst_busy", bus.rd_busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    repeat (10) @(posedge clk);
    #1;
    chk("t6_idle_busy", bus.rd_busy, 0);
    chk("t6_idle_cmds", act_n + rd_n + pre_n + exit_n, 0);
    bus.sdr_rdata_ready = 1'b1;
    start(2'd2, 13'h0010, 9'h005, 12'd2);
    wait_exit(100);
    repeat (30) @(posedge clk);
    chk("t6_exit_n", exit_n, 1);
    chk_stream("t6", 1, 2'd2, 13'h0010, 9'h005);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_rd_stream.md
Name: sdr_rd_stream

Overview:
- Streaming SDRAM read engine; the read-direction counterpart of the write engine that drains the write FIFO.
- On a request it opens one row and issues single-word READ commands, one per column.
- It captures DQ after the CAS latency into an internal 16-deep read FIFO, then precharges the bank.
- The SDRAM top muxes its command outputs in the READ state; consumers pop data through a valid/ready port.

Parameters:
- CAS_LAT, 3, CAS latency in clk cycles (legal 2..3); must match the mode register (burst length 1).
- T_RCD, 3, clk cycles from ACTIVE to the first READ (at least 1).
- T_RP, 3, clk cycles from PRECHARGE to rd_exit (at least 1).
- FIFO_AW, 4, read FIFO address width; depth is 2**FIFO_AW.

Ports:
- clk  in  1  clock, 167MHz
- rst_n  in  1  reset, asynchronous, active-low
- sdr_rd_req  in  1  level; sampled only in IDLE
- sdr_rd_byte_cnt  in  12  bytes to read; words = ceil(cnt/2)
- sdr_bank_addr  in  2  bank, latched at accept
- sdr_row_addr  in  13  row, latched at accept
- sdr_col_addr  in  9  start column, latched at accept
- sdr_CKE  out  1  clock enable
- sdr_nCS  out  1  chip select
- sdr_nRAS  out  1  row address strobe
- sdr_nCAS  out  1  column address strobe
- sdr_nWE  out  1  write enable
- sdr_BA  out  2  bank address
- sdr_A  out  13  address
- sdr_DQM  out  2  data mask
- sdr_DQ_in  in  16  DQ input; the top owns the tristate
- sdr_rdata_out  out  16  FIFO head word (first-word fall-through)
- sdr_rd_vld  out  1  FIFO not empty
- sdr_rdata_ready  in  1  consumer pop; a transfer occurs when vld & ready
- rd_busy  out  1  high whenever the state is not IDLE
- rd_exit  out  1  one-cycle pulse; the access is complete

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n); all flops clear on rst_n low.
- Reset values:
  - CKE=1, nCS=1, nRAS=1, nCAS=1, nWE=1, BA=0, A=0, DQM=2'b11.
  - FIFO empty, so sdr_rd_vld=0 and sdr_rdata_out=0.
  - rd_busy=0, rd_exit=0, state=IDLE.
- All command outputs are registered; the command is visible on the pins in the cycle after the state decides it.
- Command encodings as {nCS,nRAS,nCAS,nWE}:
  - NOP = 0111
  - ACT = 0011, A=row
  - READ = 0101, A={4'b0,col}; A10=0, no auto-precharge
  - PRE = 0010, A10=0, BA=latched bank
- DQM=00 from ACT until PRE, 11 otherwise. nCS=0 while busy, 1 in IDLE.
- States and transitions:
  - IDLE -> ACT on sdr_rd_req. Latch addresses and words = (cnt+1)>>1.
  - If words=0: go IDLE -> DONE directly; no commands are issued and rd_exit still pulses.
  - ACT: issue ACT, then go to RCD.
  - RCD: wait T_RCD-1 cycles of NOP, then go to READ.
  - READ: issue READ only while credit is available (see below). Each issue increments col and decrements the remaining count.
  - Column wraps 511 -> 0 within the open row; the row is never advanced.
  - If no credit, issue NOP and stay in READ (pause).
  - After the last issue, go to DRAIN.
  - DRAIN: NOP until in_flight=0, then go to PRE.
  - PRE: issue PRE, then go to RP.
  - RP: T_RP-1 NOPs, then go to DONE.
  - DONE: rd_exit=1 for one cycle, then go to IDLE.
- Credit rule: issue READ only if fifo_count + in_flight < 2**FIFO_AW. The FIFO therefore never overflows.
- Capture: data is written into the FIFO exactly CAS_LAT cycles after the READ appears on the pins. A shift register tracks the valid bits; in_flight is the count of set bits.
- FIFO:
  - Simultaneous push and pop in one cycle is legal; the count is unchanged.
  - Pop when empty is ignored.
  - The FIFO keeps draining in any state, including after rd_exit.
- sdr_rd_req in a non-IDLE state is ignored. A new request is accepted in IDLE even if the FIFO is non-empty; the credit rule still applies.
- Reset mid-operation: the operation is abandoned, with no PRE issued. Outputs return to their reset values immediately (asynchronously) and the FIFO is flushed.

Test Plan:
- cnt=8, bank 1, row 0x0123, col 0x010, ready=1: ACT with A=0x0123/BA=1; first READ T_RCD cycles later; 4 READs with A=0x010..0x013. vld words match the model in order, then PRE, then rd_exit once.
- cnt=3: words=2; exactly 2 READs; 2 data words popped.
- cnt=0: no ACT/READ/PRE; rd_exit pulses 2 cycles after req.
- cnt=64, ready=0: READs stop after 16 outstanding and the FIFO reaches 16 with no overflow. Raising ready resumes issue; all 32 words are delivered in order.
- col=0x1FE, cnt=8: columns issued 0x1FE, 0x1FF, 0x000, 0x001.
- rst_n asserted during DRAIN: outputs go to reset values immediately, vld=0, and the FSM is in IDLE on release.
